// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state codes, frame
// geometry and the bit-period helper.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STATE_W   = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_START  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
  localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
  localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a pop in the same cycle frees room for a
// push even when full.
module sync_fifo import uart_pkg::*; #(
  parameter int WIDTH = DATA_BITS,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    fill;
  logic             do_push;
  logic             do_pop;

  assign empty   = (fill == '0);
  assign full    = (fill == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = fill;
  assign head    = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   fill <= fill + CW'(1);
        2'b01:   fill <= fill - CW'(1);
        default: fill <= fill;
      endcase
    end
  end

  // NOTE: storage is not reset; head is masked while empty so stale
  // contents are never observable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a show-ahead receive FIFO, sticky error flags and
// an enqueue interrupt. Define UART_RX_PARITY_EN for 8E1 framing.
module uart_rx import uart_pkg::*; #(
  parameter int CLK_HZ     = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_enable,
  output logic [7:0]                    rd_data,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overrun,
  output logic                          frame_error,
  input  logic                          clear_errors,
  input  logic                          interrupt_enable,
`ifdef UART_RX_PARITY_EN
  output logic                          parity_error,
`endif
  output logic                          interrupt
);

  localparam int BIT   = clks_per_bit(CLK_HZ, BAUD);
  localparam int HALF  = BIT / 2;
  localparam int CNT_W = $clog2(BIT + 1);

  logic               rx_meta;
  logic               rxs;
  logic               rxs_d;
  logic [STATE_W-1:0] state;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         idx;
  logic [7:0]         shreg;
  logic               expire;
  logic               stop_ok;
  logic               stop_bad;
  logic               push;
  logic               enq;
  logic               full;

  // Synchroniser idles high so reset never fabricates a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  assign expire   = (cnt == '0);
  assign stop_ok  = (state == ST_STOP) && expire && rxs;
  assign stop_bad = (state == ST_STOP) && expire && !rxs;

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  logic par_set;
  assign par_set = (state == ST_PARITY) && expire && (^{shreg, rxs});
  assign push    = stop_ok && !par_bad;
`else
  assign push    = stop_ok;
`endif

  // full implies non-empty, so rd_enable here is a real pop making room.
  assign enq = push & (~full | rd_enable);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (rxs_d && !rxs) begin
            cnt   <= CNT_W'(HALF - 1);
            state <= ST_START;
          end
        end
        ST_START: begin
          if (!expire) begin
            cnt <= cnt - CNT_W'(1);
          end else if (rxs) begin
            state <= ST_IDLE;
          end else begin
            cnt   <= CNT_W'(BIT - 1);
            idx   <= '0;
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (!expire) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            shreg[idx] <= rxs;
            cnt        <= CNT_W'(BIT - 1);
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (!expire) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            par_bad <= ^{shreg, rxs};
            cnt     <= CNT_W'(BIT - 1);
            state   <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (!expire) cnt <= cnt - CNT_W'(1);
          else         state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A same-cycle set outranks clear_errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun     <= 1'b0;
      frame_error <= 1'b0;
      interrupt   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error <= 1'b0;
`endif
    end else begin
      interrupt <= enq & interrupt_enable;
      if (push && full && !rd_enable) overrun <= 1'b1;
      else if (clear_errors)          overrun <= 1'b0;
      if (stop_bad)          frame_error <= 1'b1;
      else if (clear_errors) frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      if (par_set)           parity_error <= 1'b1;
      else if (clear_errors) parity_error <= 1'b0;
`endif
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shreg),
    .pop       (rd_enable),
    .head      (rd_data),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames plus hand-written
// glitch, overrun, full-with-pop and mid-frame reset sequences.
module tb_uart_rx;

  localparam int CLK_HZ = 27000000;
  localparam int BAUD   = 115200;
  localparam int DEPTH  = 4;
  localparam int BIT    = CLK_HZ / BAUD;
  localparam int HALF   = BIT / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PRE_STOP = 10;
`else
  localparam int PRE_STOP = 9;
`endif

  logic       clk;
  logic       rst;
  logic       rx;
  logic       rd_enable;
  logic [7:0] rd_data;
  logic       empty;
  logic [2:0] count;
  logic       overrun;
  logic       frame_error;
  logic       clear_errors;
  logic       interrupt_enable;
  logic       interrupt;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
`endif

  uart_rx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .rx               (rx),
    .rd_enable        (rd_enable),
    .rd_data          (rd_data),
    .empty            (empty),
    .count            (count),
    .overrun          (overrun),
    .frame_error      (frame_error),
    .clear_errors     (clear_errors),
    .interrupt_enable (interrupt_enable),
`ifdef UART_RX_PARITY_EN
    .parity_error     (parity_error),
`endif
    .interrupt        (interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         vectors     = 0;
  int         miscompares = 0;
  int         irq_cycles  = 0;
  int         irq_misalign = 0;
  logic [7:0] sb [$];

  // interrupt must coincide with the byte being visible in the FIFO
  always @(negedge clk) begin
    if (!rst && interrupt) begin
      irq_cycles++;
      if (empty) irq_misalign++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // NOTE: stimulus is driven with blocking assignments on the falling edge,
  // half a cycle away from the edge the DUT samples on.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = ^b;
    repeat (BIT) @(negedge clk);
`endif
    rx = stop_bit;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic pop_check(input string name);
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: scoreboard empty, rd_data 0x%0h", name, rd_data);
    end else begin
      check(name, {24'd0, rd_data}, {24'd0, sb.pop_front()});
    end
    rd_enable = 1'b1;
    @(negedge clk);
    rd_enable = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    @(negedge clk);
    clear_errors = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       irq_en;
    logic       exp_ferr;
    int         exp_irq;
  } vec_t;

  vec_t vecs [6];
  int   base;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b1, 0};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0, 1};
    vecs[3] = '{8'hFF, 1'b1, 1'b0, 1'b0, 0};
    vecs[4] = '{8'h5A, 1'b1, 1'b1, 1'b0, 1};
    vecs[5] = '{8'h81, 1'b0, 1'b0, 1'b1, 0};

    rst = 1'b1; rx = 1'b1; rd_enable = 1'b0;
    clear_errors = 1'b0; interrupt_enable = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_empty", {31'd0, empty}, 32'd1);
    check("reset_count", {29'd0, count}, 32'd0);
    check("reset_rd_data", {24'd0, rd_data}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);
    check("reset_frame_error", {31'd0, frame_error}, 32'd0);
    check("reset_interrupt", {31'd0, interrupt}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      interrupt_enable = vecs[i].irq_en;
      base = irq_cycles;
      send_byte(vecs[i].data, vecs[i].stop_bit);
      if (vecs[i].stop_bit) sb.push_back(vecs[i].data);
      check("vec_frame_error", {31'd0, frame_error}, {31'd0, vecs[i].exp_ferr});
      check("vec_count", {29'd0, count}, sb.size());
      check("vec_irq_cycles", irq_cycles - base, vecs[i].exp_irq);
      check("vec_overrun", {31'd0, overrun}, 32'd0);
      if (vecs[i].stop_bit) begin
        pop_check("vec_rd_data");
        check("vec_empty_after_pop", {31'd0, empty}, 32'd1);
      end
      if (vecs[i].exp_ferr) begin
        pulse_clear();
        check("vec_frame_error_cleared", {31'd0, frame_error}, 32'd0);
      end
    end

    // short low glitch must be rejected at the start-bit midpoint
    interrupt_enable = 1'b1;
    base = irq_cycles;
    rx = 1'b0;
    repeat (50) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("glitch_count", {29'd0, count}, 32'd0);
    check("glitch_irq", irq_cycles - base, 32'd0);
    check("glitch_frame_error", {31'd0, frame_error}, 32'd0);
    check("glitch_overrun", {31'd0, overrun}, 32'd0);
    send_byte(8'h66, 1'b1);
    sb.push_back(8'h66);
    check("post_glitch_count", {29'd0, count}, 32'd1);
    pop_check("post_glitch_rd_data");

    // overrun: five bytes into a four-entry FIFO
    for (int b = 1; b <= 5; b++) begin
      send_byte(8'(b), 1'b1);
      if (sb.size() < DEPTH) sb.push_back(8'(b));
    end
    check("ovr_count", {29'd0, count}, 32'd4);
    check("ovr_overrun", {31'd0, overrun}, 32'd1);
    for (int k = 0; k < DEPTH; k++) pop_check("ovr_rd_data");
    check("ovr_empty", {31'd0, empty}, 32'd1);
    pulse_clear();
    check("ovr_cleared", {31'd0, overrun}, 32'd0);

    // full FIFO with a pop landing on the enqueue cycle
    for (int b = 8'h10; b <= 8'h13; b++) begin
      send_byte(8'(b), 1'b1);
      sb.push_back(8'(b));
    end
    check("full_count", {29'd0, count}, 32'd4);
    fork
      send_byte(8'h14, 1'b1);
      begin
        @(negedge clk);
        repeat (2 + HALF + PRE_STOP * BIT) @(posedge clk);
        @(negedge clk);
        check("simul_head", {24'd0, rd_data}, {24'd0, sb.pop_front()});
        sb.push_back(8'h14);
        rd_enable = 1'b1;
        @(negedge clk);
        rd_enable = 1'b0;
      end
    join
    check("simul_count", {29'd0, count}, 32'd4);
    check("simul_overrun", {31'd0, overrun}, 32'd0);
    for (int k = 0; k < DEPTH; k++) pop_check("simul_rd_data");

    // reset mid-DATA of 0x77 abandons the byte
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = 1'(8'h77 >> i);
      repeat (BIT) @(negedge clk);
    end
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_count", {29'd0, count}, 32'd0);
    check("midrst_rd_data", {24'd0, rd_data}, 32'd0);
    check("midrst_frame_error", {31'd0, frame_error}, 32'd0);
    repeat (2 * BIT) @(negedge clk);
    base = irq_cycles;
    send_byte(8'h12, 1'b1);
    sb.push_back(8'h12);
    check("midrst_only_one", {29'd0, count}, 32'd1);
    check("midrst_irq", irq_cycles - base, 32'd1);
    pop_check("midrst_rd_data_12");
    check("midrst_empty", {31'd0, empty}, 32'd1);

    check("irq_alignment", irq_misalign, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
